// File: rtl/mult_pkg.sv
// Shared types and constants for the 8x8 signed shift-add multiplier sequencer.
//   mult_state_t : sequencer state encoding
//   MULT_WIDTH   : operand width expected by register_unit
//   ITER_LAST    : final iteration index (the subtract step)
package mult_pkg;

  localparam int unsigned MULT_WIDTH = 8;
  localparam int unsigned ITER_W     = 3;
  localparam logic [ITER_W-1:0] ITER_LAST = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOADB = 3'd1,
    S_CLRA  = 3'd2,
    S_CLR   = 3'd3,
    S_ADD   = 3'd4,
    S_SHIFT = 3'd5,
    S_HOLD  = 3'd6
  } mult_state_t;

endpackage

// File: rtl/add_sub9.sv
// 9-bit sign-extending adder/subtractor for the partial-product step.
//   a   in  8  current A register (signed)
//   s   in  8  multiplicand (signed)
//   sub in  1  1 = a - s, 0 = a + s
//   sum out 9  sign-extended result; sum[8] becomes the new X
module add_sub9 (
  input  logic [7:0] a,
  input  logic [7:0] s,
  input  logic       sub,
  output logic [8:0] sum
);

  logic [8:0] a_ext;
  logic [8:0] s_ext;

  assign a_ext = {a[7], a};
  assign s_ext = {s[7], s};

  // Wraps modulo 2^9, which is exactly what the sign-extension bit needs.
  assign sum = sub ? (a_ext - s_ext) : (a_ext + s_ext);

endmodule

// File: rtl/mult_sequencer.sv
// Control and datapath-drive side of the 8x8 signed shift-add multiplier.
// Drives register_unit (load/shift/serial/data), owns the sign bit X and the
// add/subtract path. The 16-bit product ends up in {A,B}, X holds its sign.
//   Clk, Reset            clock, synchronous active-high reset
//   Run, ClearA_LoadB     start multiply / load B and clear A (sampled in IDLE)
//   Sw                    multiplicand, also the value loaded into B
//   A, B, A_out, B_out    register_unit contents and LSBs
//   Ld_A, Ld_B, Shift_En  register_unit controls (combinational decode)
//   A_In, B_In, D_in      register_unit serial inputs and load data
//   X                     sign-extension bit of A (registered)
//   Busy, Done            multiply in progress / result valid
module mult_sequencer
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             ClearA_LoadB,
  input  logic [WIDTH-1:0] Sw,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             A_out,
  input  logic             B_out,
  output logic             Ld_A,
  output logic             Ld_B,
  output logic             Shift_En,
  output logic             A_In,
  output logic             B_In,
  output logic [WIDTH-1:0] D_in,
  output logic             X,
  output logic             Busy,
  output logic             Done
);

  // register_unit and the 9-bit adder are both fixed at 8 bits.
  if (WIDTH != MULT_WIDTH) begin : g_width_check
    $error("mult_sequencer: WIDTH must be 8");
  end

  mult_state_t       state, state_nxt;
  logic [ITER_W-1:0] k, k_nxt;
  logic              x, x_nxt;
  logic              sub;
  logic [8:0]        sum;
  logic              unused_b;

  // M comes from B_out; the full B bus is not needed by the sequencer.
  assign unused_b = ^B;

  // Last iteration weighs the multiplier's sign bit negatively.
  assign sub = (k == ITER_LAST);

  add_sub9 u_add_sub9 (
    .a   (A),
    .s   (Sw),
    .sub (sub),
    .sum (sum)
  );

  assign X = x;

  // State, iteration counter and sign bit.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= S_IDLE;
      k     <= '0;
      x     <= 1'b0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      x     <= x_nxt;
    end
  end

  // Next-state and control decode; everything forced low while in reset.
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    x_nxt     = x;
    Ld_A      = 1'b0;
    Ld_B      = 1'b0;
    Shift_En  = 1'b0;
    A_In      = 1'b0;
    B_In      = 1'b0;
    D_in      = '0;
    Busy      = 1'b0;
    Done      = 1'b0;

    if (!Reset) begin
      unique case (state)
        S_IDLE: begin
          if (Run)               state_nxt = S_CLR;
          else if (ClearA_LoadB) state_nxt = S_LOADB;
        end
        S_LOADB: begin
          Ld_B      = 1'b1;
          D_in      = Sw;
          state_nxt = S_CLRA;
        end
        S_CLRA: begin
          Ld_A      = 1'b1;
          x_nxt     = 1'b0;
          state_nxt = S_IDLE;
        end
        S_CLR: begin
          // B is deliberately kept so a new Run multiplies the previous low byte.
          Busy      = 1'b1;
          Ld_A      = 1'b1;
          x_nxt     = 1'b0;
          k_nxt     = '0;
          state_nxt = S_ADD;
        end
        S_ADD: begin
          Busy = 1'b1;
          if (B_out) begin
            Ld_A  = 1'b1;
            D_in  = sum[WIDTH-1:0];
            x_nxt = sum[WIDTH];
          end
          state_nxt = S_SHIFT;
        end
        S_SHIFT: begin
          Busy     = 1'b1;
          Shift_En = 1'b1;
          A_In     = x;
          B_In     = A_out;
          if (k == ITER_LAST) begin
            state_nxt = S_HOLD;
          end else begin
            k_nxt     = ITER_W'(k + 3'd1);
            state_nxt = S_ADD;
          end
        end
        S_HOLD: begin
          Done = 1'b1;
          if (!Run) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

endmodule
